// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between instruction memory responses and decode. Define FETCHQ_BYPASS_EN for a 0-cycle empty-queue bypass.
// Latency: 1 cycle from response to out_valid (0 with bypass). Responses are never back-pressured; req_allow throttles issue by credits.
module fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       flush,
   input  logic                       req_fire,
   output logic                       req_allow,
   input  logic                       resp_valid,
   input  logic [PC_W-1:0]            resp_pc,
   input  logic [DATA_W-1:0]          resp_instr,
   input  logic                       resp_addr_err,
   input  logic                       resp_ds,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_W-1:0]            out_pc,
   output logic [DATA_W-1:0]          out_instr,
   output logic                       out_addr_err,
   output logic                       out_ds,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic                       ovf_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] instr;
      logic              addr_err;
      logic              ds;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic               ovf_err_q, ovf_err_d;

   entry_t             resp_ent;
   entry_t             head;
   entry_t             out_ent;
   logic               resp_ok;
   logic               enq;
   logic               deq;
   logic               full;
   logic               byp;
   logic               byp_take;
   logic               wr_en;
   logic [CNT_W:0]     credit_sum;

   assign resp_ent = '{pc: resp_pc, instr: resp_instr, addr_err: resp_addr_err, ds: resp_ds};
   assign head     = mem_q[rd_ptr_q];

   always_comb begin
      // A response with nothing outstanding is a protocol error and is ignored entirely.
      resp_ok    = resp_valid & (outstanding_q != '0);
      enq        = resp_ok & (drop_cnt_q == '0) & ~flush;
      full       = (count_q == CNT_W'(DEPTH));
      deq        = (count_q != '0) & out_ready & ~flush;
`ifdef FETCHQ_BYPASS_EN
      byp        = enq & (count_q == '0);
`else
      byp        = 1'b0;
`endif
      byp_take   = byp & out_ready;
      wr_en      = enq & ~byp_take & (~full | deq);
      credit_sum = {1'b0, count_q} + {1'b0, outstanding_q};
      req_allow  = (credit_sum < (CNT_W + 1)'(DEPTH));
   end

   always_comb begin
      out_valid = (count_q != '0) | byp;
      if (count_q != '0) begin
         out_ent = head;
      end else if (byp) begin
         out_ent = resp_ent;
      end else begin
         out_ent = '0;
      end
      out_pc       = out_ent.pc;
      out_instr    = out_ent.instr;
      out_addr_err = out_ent.addr_err;
      out_ds       = out_ent.ds;
      occupancy    = count_q;
      ovf_err      = ovf_err_q;
   end

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      ovf_err_d     = ovf_err_q;

      // Outstanding saturates rather than wrapping when issue ignores req_allow.
      if (req_fire & ~resp_ok) begin
         if (outstanding_q != '1) begin
            outstanding_d = outstanding_q + 1'b1;
         end
      end else if (~req_fire & resp_ok) begin
         outstanding_d = outstanding_q - 1'b1;
      end

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         drop_cnt_d = outstanding_q - CNT_W'(resp_ok);
      end else begin
         wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
         rd_ptr_d = rd_ptr_q + PTR_W'(deq);
         count_d  = count_q + CNT_W'(wr_en) - CNT_W'(deq);
         if (resp_ok && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
         end
      end

      if ((enq & full & ~deq) | (resp_valid & (outstanding_q == '0)) | (req_fire & ~req_allow)) begin
         ovf_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         ovf_err_q     <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         ovf_err_q     <= ovf_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= resp_ent;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based reference model checked every cycle, plus literal expectations.
module tb_fetch_queue;
   localparam int DEPTH = 4;
`ifdef FETCHQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        flush = 1'b0;
   logic        req_fire = 1'b0;
   logic        req_allow;
   logic        resp_valid = 1'b0;
   logic [31:0] resp_pc = '0;
   logic [31:0] resp_instr = '0;
   logic        resp_addr_err = 1'b0;
   logic        resp_ds = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_addr_err;
   logic        out_ds;
   logic [2:0]  occupancy;
   logic        ovf_err;

   fetch_queue #(.DEPTH(DEPTH), .DATA_W(32), .PC_W(32)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .req_fire(req_fire), .req_allow(req_allow),
      .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_instr(resp_instr),
      .resp_addr_err(resp_addr_err), .resp_ds(resp_ds), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .out_addr_err(out_addr_err), .out_ds(out_ds), .occupancy(occupancy), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an ordered list of queued instructions plus credit/drop counters.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ae;
      logic        ds;
   } ent_t;

   ent_t m_q[$];
   int   m_outs = 0;
   int   m_drop = 0;
   bit   m_ovf  = 0;

   always @(negedge resetn) begin
      m_q.delete();
      m_outs = 0;
      m_drop = 0;
      m_ovf  = 0;
   end

   always @(posedge clk) begin : model_step
      int   sz;
      bit   acc, pop, push;
      ent_t e;
      if (resetn) begin
         sz  = m_q.size();
         acc = resp_valid && (m_outs > 0);
         if (resp_valid && m_outs == 0) m_ovf = 1;
         if (req_fire && (sz + m_outs >= DEPTH)) m_ovf = 1;
         if (flush) begin
            m_q.delete();
            m_drop = m_outs - int'(acc);
         end else begin
            pop  = (sz > 0) && out_ready;
            push = 0;
            if (acc) begin
               if (m_drop > 0) m_drop--;
               else push = 1;
            end
            if (push && BYP && sz == 0 && out_ready) push = 0;
            if (push && sz == DEPTH && !pop) begin
               m_ovf = 1;
               push  = 0;
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
               e.pc = resp_pc; e.instr = resp_instr; e.ae = resp_addr_err; e.ds = resp_ds;
               m_q.push_back(e);
            end
         end
         m_outs = m_outs + int'(req_fire) - int'(acc);
      end
   end

   // Compare process: every cycle on the falling edge, inputs for the cycle already applied.
   always @(negedge clk) begin : compare
      bit   bypv;
      bit   ev;
      ent_t h;
      bypv = BYP && m_q.size() == 0 && resp_valid && m_outs > 0 && m_drop == 0 && !flush && resetn;
      ev   = (m_q.size() != 0) || bypv;
      if (m_q.size() != 0) h = m_q[0];
      else begin
         h.pc = resp_pc; h.instr = resp_instr; h.ae = resp_addr_err; h.ds = resp_ds;
      end
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("occupancy", 64'(occupancy), 64'(m_q.size()));
      chk("req_allow", 64'(req_allow), 64'((m_q.size() + m_outs) < DEPTH));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
      if (ev) begin
         chk("out_pc", 64'(out_pc), 64'(h.pc));
         chk("out_instr", 64'(out_instr), 64'(h.instr));
         chk("out_addr_err", 64'(out_addr_err), 64'(h.ae));
         chk("out_ds", 64'(out_ds), 64'(h.ds));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_in(input bit rf, input bit rv, input logic [31:0] pc, input bit rdy, input bit fl);
      req_fire      = rf;
      resp_valid    = rv;
      resp_pc       = rv ? pc : 32'h0;
      resp_instr    = rv ? (pc ^ 32'h2400_5A5A) : 32'h0;
      resp_addr_err = rv & pc[4];
      resp_ds       = rv & pc[2];
      out_ready     = rdy;
      flush         = fl;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, 0);
      resetn = 1'b0;
      cyc();
      cyc();
      resetn = 1'b1;
   endtask

   initial begin
      do_reset();
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_ovf", 64'(ovf_err), 64'd0);
      chk("rst_req_allow", 64'(req_allow), 64'd1);
      cyc();

      // Fill to DEPTH with decode stalled, then drain in order.
      for (int i = 0; i < 4; i++) begin set_in(1, 0, 0, 0, 0); cyc(); end
      for (int i = 0; i < 4; i++) begin set_in(0, 1, 32'hBFC0_0000 + 32'(4 * i), 0, 0); cyc(); end
      set_in(0, 0, 0, 0, 0);
      #1;
      chk("fill_occ", 64'(occupancy), 64'd4);
      chk("fill_allow", 64'(req_allow), 64'd0);
      chk("fill_head", 64'(out_pc), 64'hBFC0_0000);
      cyc();
      for (int i = 0; i < 4; i++) begin
         set_in(0, 0, 0, 1, 0);
         #1;
         chk("drain_pc", 64'(out_pc), 64'(32'hBFC0_0000 + 32'(4 * i)));
         cyc();
      end
      set_in(0, 0, 0, 0, 0);
      cyc();

      // Streaming: one in flight, decode always ready; pointers wrap repeatedly.
      set_in(1, 0, 0, 1, 0);
      cyc();
      for (int i = 1; i <= 10; i++) begin
         set_in(i < 10, 1, 32'hBFC0_0040 + 32'(4 * (i - 1)), 1, 0);
         if (i >= 2) begin
            #1;
            chk("stream_occ", 64'(occupancy), 64'd1);
            chk("stream_pc", 64'(out_pc), 64'(32'hBFC0_0040 + 32'(4 * (i - 2))));
         end
         cyc();
      end
      set_in(0, 0, 0, 1, 0);
      #1;
      chk("stream_ovf", 64'(ovf_err), 64'd0);
      cyc();
      set_in(0, 0, 0, 0, 0);
      cyc();

      // Flush with 2 queued, 2 outstanding, redirect request in the flush cycle.
      for (int i = 0; i < 4; i++) begin set_in(1, 0, 0, 0, 0); cyc(); end
      set_in(0, 1, 32'hBFC0_0080, 0, 0); cyc();
      set_in(0, 1, 32'hBFC0_0084, 0, 0); cyc();
      set_in(1, 0, 0, 0, 1); cyc();
      set_in(0, 0, 0, 0, 0);
      #1;
      chk("flush_occ", 64'(occupancy), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_ovf", 64'(ovf_err), 64'd1);
      cyc();
      set_in(0, 1, 32'hBFC0_0088, 0, 0); cyc();
      set_in(0, 1, 32'hBFC0_008C, 0, 0); cyc();
      set_in(0, 1, 32'hBFC0_0100, 0, 0); cyc();
      set_in(0, 0, 0, 1, 0);
      #1;
      chk("redirect_valid", 64'(out_valid), 64'd1);
      chk("redirect_pc", 64'(out_pc), 64'hBFC0_0100);
      cyc();
      set_in(0, 0, 0, 0, 0);
      cyc();

      // Flush coincident with a response, outstanding=3: three responses discarded in total.
      do_reset();
      for (int i = 0; i < 3; i++) begin set_in(1, 0, 0, 0, 0); cyc(); end
      set_in(0, 1, 32'hBFC0_0180, 0, 1); cyc();
      set_in(0, 1, 32'hBFC0_0184, 0, 0); cyc();
      set_in(0, 1, 32'hBFC0_0188, 0, 0); cyc();
      set_in(1, 0, 0, 0, 0);
      #1;
      chk("drop_valid", 64'(out_valid), 64'd0);
      chk("drop_occ", 64'(occupancy), 64'd0);
      cyc();
      set_in(0, 1, 32'hBFC0_0200, 0, 0); cyc();
      set_in(0, 0, 0, 1, 0);
      #1;
      chk("after_drop_pc", 64'(out_pc), 64'hBFC0_0200);
      chk("after_drop_ovf", 64'(ovf_err), 64'd0);
      cyc();

      // Protocol error, then asynchronous reset mid-stream.
      set_in(0, 1, 32'hBFC0_0300, 0, 0); cyc();
      set_in(0, 0, 0, 0, 0);
      #1;
      chk("proto_ovf", 64'(ovf_err), 64'd1);
      chk("proto_valid", 64'(out_valid), 64'd0);
      cyc();
      cyc();
      chk("proto_sticky", 64'(ovf_err), 64'd1);
      set_in(1, 0, 0, 0, 0); cyc();
      set_in(1, 1, 32'hBFC0_0310, 0, 0); cyc();
      set_in(0, 0, 0, 0, 0);
      resetn = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_occ", 64'(occupancy), 64'd0);
      chk("arst_ovf", 64'(ovf_err), 64'd0);
      chk("arst_pc", 64'(out_pc), 64'd0);
      cyc();
      resetn = 1'b1;
      cyc();

      // Empty-queue latency: bypass build presents the response the same cycle.
      set_in(1, 0, 0, 1, 0); cyc();
      set_in(0, 1, 32'hBFC0_0020, 1, 0);
      #1;
      chk("lat0_valid", 64'(out_valid), 64'(BYP));
      chk("lat0_occ", 64'(occupancy), 64'd0);
      if (BYP) chk("lat0_pc", 64'(out_pc), 64'hBFC0_0020);
      cyc();
      set_in(0, 0, 0, 1, 0);
      #1;
      chk("lat1_valid", 64'(out_valid), 64'(!BYP));
      if (!BYP) chk("lat1_pc", 64'(out_pc), 64'hBFC0_0020);
      cyc();
      set_in(0, 0, 0, 0, 0);
      #1;
      chk("lat_done_valid", 64'(out_valid), 64'd0);
      cyc();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
